rice_core_execute_stage: RTL and testbench
==========================================

RICE_CORE_EXECUTE_STAGE -- requirements
Module: rice_core_execute_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have port i_clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports i_valid input 1 and o_ready output 1, the upstream decode handshake.
REQ-005 SHALL have ports i_pc, i_rs1_value, i_rs2_value, i_imm_value  input  XLEN each  instruction operands.
REQ-006 SHALL have port i_alu_operation  input  rice_core_alu_operation  ALU command and source selects.
REQ-007 SHALL have ports i_rd input 5 (destination register) and i_rd_write input 1 (write-enable).
REQ-008 SHALL have port i_branch_op  input  3  branch kind: 0 NONE, 1 EQ, 2 NE, 3 LT, 4 GE, 5 LTU, 6 GEU, 7 JUMP.
REQ-009 SHALL have port i_jump_rs1  input  1  JUMP base select: 1 rs1 (JALR), 0 pc (JAL).
REQ-010 SHALL have port i_flush  input  1  external kill of the stage contents.
REQ-011 SHALL have ports o_valid output 1 and i_ready input 1, the downstream writeback handshake.
REQ-012 SHALL have ports o_rd output 5, o_rd_write output 1 and o_result output XLEN, the registered writeback payload.
REQ-013 SHALL have ports o_flush output 1 and o_flush_pc output XLEN, the redirect request to fetch/decode.
REQ-014 SHALL have port o_misaligned  output  1  redirect target not 4-byte aligned.

Function
REQ-015 SHALL instantiate rice_core_alu with i_pc, i_rs1_value, i_rs2_value, i_imm_value and i_alu_operation.
REQ-016 SHALL drive o_ready = !i_flush && !o_flush && (!o_valid || i_ready) (combinational).
REQ-017 SHALL accept an input in a cycle where i_valid && o_ready, capturing the payload at that edge; latency is 1 cycle.
REQ-018 SHALL set o_valid on accept, hold o_valid and the payload stable while o_valid && !i_ready, and clear o_valid on o_valid && i_ready with no new accept.
REQ-019 SHALL capture o_result = i_pc + 4 (modulo 2^XLEN) for JUMP, otherwise the ALU result.
REQ-020 SHALL compute taken: EQ rs1==rs2; NE rs1!=rs2; LT signed <; GE signed >=; LTU unsigned <; GEU unsigned >=; JUMP always; NONE never.
REQ-021 SHALL compute target = pc + imm for conditional branches and for JUMP with i_jump_rs1=0, and (rs1 + imm) with bit 0 cleared for JUMP with i_jump_rs1=1; all additions wrap modulo 2^XLEN.
REQ-022 SHALL, on accepting a taken instruction, register o_flush=1 and o_flush_pc=target for exactly one cycle, coincident with the first o_valid cycle of that instruction.
REQ-023 SHALL register o_misaligned = target[1] with the taken instruction, hold it with the payload, and also suppress o_flush (o_flush=0) for that instruction.
REQ-024 SHALL keep o_flush_pc at its last value when o_flush=0.
REQ-025 SHALL, on i_flush=1, clear o_valid, o_flush and o_misaligned at the next edge and accept nothing in that cycle, regardless of i_ready.
REQ-026 SHALL, when i_flush and a held o_valid && i_ready coincide, treat the downstream transfer as completed and still clear o_valid.
REQ-027 SHALL block accept during the o_flush cycle so no wrong-path instruction enters the stage.

Reset
REQ-028 SHALL, while i_rst_n=0, force o_valid=0, o_flush=0, o_misaligned=0, o_rd_write=0, o_rd=0, o_result=0 and o_flush_pc=0 asynchronously.
REQ-029 SHALL treat reset asserted mid-transfer as a discard, with no output pulse after release.
REQ-030 SHALL, after reset release, accept on the first edge with i_valid=1, i_flush=0.

Verification
REQ-031 SHALL cover: ADD op with rs1=5 and rs2=7, rd=3 -> next cycle o_valid=1, o_result=12, o_rd=3.
REQ-032 SHALL cover: o_valid=1 with i_ready=0 for 3 cycles and i_valid=1 -> o_ready=0, payload stable; i_ready=1 -> transfer, new accept same edge.
REQ-033 SHALL cover: BLT with rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> o_flush=1 for one cycle, o_flush_pc=0x120; the same operands with BLTU -> o_flush=0.
REQ-034 SHALL cover: JUMP with i_jump_rs1=1, rs1=0x203, imm=0, pc=0x40 -> o_flush_pc=0x202, o_misaligned=1, o_flush=0, o_result=0x44.
REQ-035 SHALL cover: JUMP with pc=0xFFFFFFFC and imm=8 -> o_flush_pc=0x4, o_result=0x0 (wrap).
REQ-036 SHALL cover: i_flush with held o_valid and i_ready=0 -> o_valid=0 next cycle; reset asserted with o_valid=1 -> all outputs 0 immediately.

Source files
------------

// File: rtl/rice_core_pkg.sv
// Shared types for the rice core: ALU command encoding and operand source selects.
package rice_core_pkg;

    typedef struct packed {
        logic [3:0] op;
        logic       a_pc;   // operand A = pc instead of rs1
        logic       b_imm;  // operand B = imm instead of rs2
    } rice_core_alu_operation;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluSll  = 4'd2;
    localparam logic [3:0] AluSlt  = 4'd3;
    localparam logic [3:0] AluSltu = 4'd4;
    localparam logic [3:0] AluXor  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluOr   = 4'd8;
    localparam logic [3:0] AluAnd  = 4'd9;
    localparam logic [3:0] AluPassB = 4'd10;

endpackage

// File: rtl/rice_core_alu.sv
// Combinational integer ALU with pc/rs1 and imm/rs2 operand selection.
module rice_core_alu
    import rice_core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]       i_pc,
    input  logic [XLEN-1:0]       i_rs1_value,
    input  logic [XLEN-1:0]       i_rs2_value,
    input  logic [XLEN-1:0]       i_imm_value,
    input  rice_core_alu_operation i_alu_operation,
    output logic [XLEN-1:0]       o_result
);

    localparam int unsigned ShW = $clog2(XLEN);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [ShW-1:0]  shamt;

    assign op_a  = i_alu_operation.a_pc  ? i_pc        : i_rs1_value;
    assign op_b  = i_alu_operation.b_imm ? i_imm_value : i_rs2_value;
    assign shamt = op_b[ShW-1:0];

    always_comb begin
        o_result = '0;
        case (i_alu_operation.op)
            AluAdd:   o_result = op_a + op_b;
            AluSub:   o_result = op_a - op_b;
            AluSll:   o_result = op_a << shamt;
            AluSlt:   o_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            AluSltu:  o_result = {{(XLEN-1){1'b0}}, op_a < op_b};
            AluXor:   o_result = op_a ^ op_b;
            AluSrl:   o_result = op_a >> shamt;
            AluSra:   o_result = $unsigned($signed(op_a) >>> shamt);
            AluOr:    o_result = op_a | op_b;
            AluAnd:   o_result = op_a & op_b;
            AluPassB: o_result = op_b;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/rice_core_execute_stage.sv
// Execute stage: ALU, branch resolution and a one-entry registered output with
// valid/ready handshakes on both sides and a one-cycle redirect pulse.
module rice_core_execute_stage
    import rice_core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [XLEN-1:0]        i_pc,
    input  logic [XLEN-1:0]        i_rs1_value,
    input  logic [XLEN-1:0]        i_rs2_value,
    input  logic [XLEN-1:0]        i_imm_value,
    input  rice_core_alu_operation i_alu_operation,
    input  logic [4:0]             i_rd,
    input  logic                   i_rd_write,
    input  logic [2:0]             i_branch_op,
    input  logic                   i_jump_rs1,
    input  logic                   i_flush,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [4:0]             o_rd,
    output logic                   o_rd_write,
    output logic [XLEN-1:0]        o_result,
    output logic                   o_flush,
    output logic [XLEN-1:0]        o_flush_pc,
    output logic                   o_misaligned
);

    localparam logic [2:0] BrNone = 3'd0;
    localparam logic [2:0] BrEq   = 3'd1;
    localparam logic [2:0] BrNe   = 3'd2;
    localparam logic [2:0] BrLt   = 3'd3;
    localparam logic [2:0] BrGe   = 3'd4;
    localparam logic [2:0] BrLtu  = 3'd5;
    localparam logic [2:0] BrGeu  = 3'd6;
    localparam logic [2:0] BrJump = 3'd7;

    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc_target;
    logic [XLEN-1:0] rs1_target;
    logic [XLEN-1:0] target;
    logic            taken;
    logic            is_jump;
    logic            accept;

    logic            valid_q, valid_d;
    logic [4:0]      rd_q, rd_d;
    logic            rd_write_q, rd_write_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] flush_pc_q, flush_pc_d;
    logic            misaligned_q, misaligned_d;

    rice_core_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .i_pc           (i_pc),
        .i_rs1_value    (i_rs1_value),
        .i_rs2_value    (i_rs2_value),
        .i_imm_value    (i_imm_value),
        .i_alu_operation(i_alu_operation),
        .o_result       (alu_result)
    );

    assign is_jump    = (i_branch_op == BrJump);
    assign pc_target  = i_pc + i_imm_value;
    assign rs1_target = i_rs1_value + i_imm_value;
    assign target     = (is_jump && i_jump_rs1) ? {rs1_target[XLEN-1:1], 1'b0} : pc_target;

    always_comb begin
        taken = 1'b0;
        case (i_branch_op)
            BrNone:  taken = 1'b0;
            BrEq:    taken = (i_rs1_value == i_rs2_value);
            BrNe:    taken = (i_rs1_value != i_rs2_value);
            BrLt:    taken = ($signed(i_rs1_value) <  $signed(i_rs2_value));
            BrGe:    taken = ($signed(i_rs1_value) >= $signed(i_rs2_value));
            BrLtu:   taken = (i_rs1_value <  i_rs2_value);
            BrGeu:   taken = (i_rs1_value >= i_rs2_value);
            BrJump:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // The redirect cycle blocks accept so no wrong-path instruction slips in.
    assign o_ready = !i_flush && !flush_q && (!valid_q || i_ready);
    assign accept  = i_valid && o_ready;

    always_comb begin
        valid_d      = valid_q;
        rd_d         = rd_q;
        rd_write_d   = rd_write_q;
        result_d     = result_q;
        flush_d      = 1'b0;
        flush_pc_d   = flush_pc_q;
        misaligned_d = misaligned_q;

        if (accept) begin
            valid_d      = 1'b1;
            rd_d         = i_rd;
            rd_write_d   = i_rd_write;
            result_d     = is_jump ? (i_pc + XLEN'(4)) : alu_result;
            misaligned_d = taken && target[1];
            flush_d      = taken && !target[1];
            if (taken) begin
                flush_pc_d = target;
            end
        end else if (valid_q && i_ready) begin
            valid_d      = 1'b0;
            misaligned_d = 1'b0;
        end

        // A kill also completes any coincident downstream transfer.
        if (i_flush) begin
            valid_d      = 1'b0;
            flush_d      = 1'b0;
            misaligned_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q      <= 1'b0;
            rd_q         <= '0;
            rd_write_q   <= 1'b0;
            result_q     <= '0;
            flush_q      <= 1'b0;
            flush_pc_q   <= '0;
            misaligned_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rd_q         <= rd_d;
            rd_write_q   <= rd_write_d;
            result_q     <= result_d;
            flush_q      <= flush_d;
            flush_pc_q   <= flush_pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_rd         = rd_q;
    assign o_rd_write   = rd_write_q;
    assign o_result     = result_q;
    assign o_flush      = flush_q;
    assign o_flush_pc   = flush_pc_q;
    assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_rice_core_execute_stage.sv
// Directed bench for the execute stage: handshake, ALU, branches, jumps, flush and reset.
module tb_rice_core_execute_stage;
    import rice_core_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   i_valid;
    logic                   o_ready;
    logic [31:0]            i_pc;
    logic [31:0]            i_rs1_value;
    logic [31:0]            i_rs2_value;
    logic [31:0]            i_imm_value;
    rice_core_alu_operation i_alu_operation;
    logic [4:0]             i_rd;
    logic                   i_rd_write;
    logic [2:0]             i_branch_op;
    logic                   i_jump_rs1;
    logic                   i_flush;
    logic                   o_valid;
    logic                   i_ready;
    logic [4:0]             o_rd;
    logic                   o_rd_write;
    logic [31:0]            o_result;
    logic                   o_flush;
    logic [31:0]            o_flush_pc;
    logic                   o_misaligned;

    int pass_cnt;
    int total_cnt;

    rice_core_execute_stage #(
        .XLEN(32)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_pc           (i_pc),
        .i_rs1_value    (i_rs1_value),
        .i_rs2_value    (i_rs2_value),
        .i_imm_value    (i_imm_value),
        .i_alu_operation(i_alu_operation),
        .i_rd           (i_rd),
        .i_rd_write     (i_rd_write),
        .i_branch_op    (i_branch_op),
        .i_jump_rs1     (i_jump_rs1),
        .i_flush        (i_flush),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_rd           (o_rd),
        .o_rd_write     (o_rd_write),
        .o_result       (o_result),
        .o_flush        (o_flush),
        .o_flush_pc     (o_flush_pc),
        .o_misaligned   (o_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_instr(input logic [3:0] op, input logic a_pc, input logic b_imm,
                             input logic [31:0] pc, input logic [31:0] rs1,
                             input logic [31:0] rs2, input logic [31:0] imm,
                             input logic [4:0] rd, input logic [2:0] br, input logic jrs1);
        i_valid               = 1'b1;
        i_alu_operation.op    = op;
        i_alu_operation.a_pc  = a_pc;
        i_alu_operation.b_imm = b_imm;
        i_pc                  = pc;
        i_rs1_value           = rs1;
        i_rs2_value           = rs2;
        i_imm_value           = imm;
        i_rd                  = rd;
        i_rd_write            = 1'b1;
        i_branch_op           = br;
        i_jump_rs1            = jrs1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL reset_valid got %h want 0", o_valid); else pass_cnt++;
        total_cnt++; if (o_flush !== 1'b0) $display("FAIL reset_flush got %h want 0", o_flush); else pass_cnt++;
        total_cnt++; if (o_misaligned !== 1'b0) $display("FAIL reset_mis got %h want 0", o_misaligned); else pass_cnt++;
        total_cnt++; if (o_rd_write !== 1'b0 || o_rd !== 5'd0) $display("FAIL reset_rd got %h/%h want 0/0", o_rd_write, o_rd); else pass_cnt++;
        total_cnt++; if (o_result !== 32'h0 || o_flush_pc !== 32'h0) $display("FAIL reset_data got %h/%h want 0/0", o_result, o_flush_pc); else pass_cnt++;
        #9;
        rst_n = 1'b1;
        #1;
        total_cnt++; if (o_ready !== 1'b1) $display("FAIL reset_ready got %h want 1", o_ready); else pass_cnt++;
    endtask

    task automatic test_add();
        i_ready = 1'b1;
        set_instr(AluAdd, 1'b0, 1'b0, 32'h0, 32'd5, 32'd7, 32'h0, 5'd3, 3'd0, 1'b0);
        tick();
        i_valid = 1'b0;
        total_cnt++; if (o_valid !== 1'b1) $display("FAIL add_valid got %h want 1", o_valid); else pass_cnt++;
        total_cnt++; if (o_result !== 32'd12) $display("FAIL add_result got %h want 0000000c", o_result); else pass_cnt++;
        total_cnt++; if (o_rd !== 5'd3 || o_rd_write !== 1'b1) $display("FAIL add_rd got %h/%h want 3/1", o_rd, o_rd_write); else pass_cnt++;
        total_cnt++; if (o_flush !== 1'b0) $display("FAIL add_flush got %h want 0", o_flush); else pass_cnt++;
        tick();
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL add_drain got %h want 0", o_valid); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops  [10] = '{AluSub, AluSlt, AluSltu, AluSra, AluSrl, AluSll, AluXor,
                                   AluAnd, AluAdd, AluAdd};
        logic        apc  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        logic        bimm [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        logic [31:0] rs1  [10] = '{32'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                   32'h80000000, 32'h1, 32'hF0F0, 32'hF0F0, 32'd100, 32'h0};
        logic [31:0] rs2  [10] = '{32'd3, 32'd1, 32'd1, 32'd4, 32'd4, 32'd31, 32'hFF00,
                                   32'hFF00, 32'h0, 32'h0};
        logic [31:0] imm  [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 32'h2000};
        logic [31:0] exp  [10] = '{32'd7, 32'd1, 32'd0, 32'hF8000000, 32'h08000000,
                                   32'h80000000, 32'h0FF0, 32'hF000, 32'd99, 32'h3000};
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_instr(ops[i], apc[i], bimm[i], 32'h1000, rs1[i], rs2[i], imm[i],
                      5'(i + 1), 3'd0, 1'b0);
            tick();
            total_cnt++;
            if (o_valid !== 1'b1 || o_result !== exp[i] || o_rd !== 5'(i + 1))
                $display("FAIL alu_vec%0d got v=%h r=%h rd=%h want v=1 r=%h rd=%h",
                         i, o_valid, o_result, o_rd, exp[i], 5'(i + 1));
            else pass_cnt++;
        end
        i_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        set_instr(AluAdd, 1'b0, 1'b0, 32'h0, 32'd1, 32'd2, 32'h0, 5'd2, 3'd0, 1'b0);
        tick();
        set_instr(AluSub, 1'b0, 1'b0, 32'h0, 32'd10, 32'd3, 32'h0, 5'd4, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total_cnt++; if (o_ready !== 1'b0) $display("FAIL bp_ready%0d got %h want 0", i, o_ready); else pass_cnt++;
            tick();
            total_cnt++;
            if (o_valid !== 1'b1 || o_result !== 32'd3 || o_rd !== 5'd2)
                $display("FAIL bp_hold%0d got v=%h r=%h rd=%h want v=1 r=3 rd=2", i, o_valid, o_result, o_rd);
            else pass_cnt++;
        end
        i_ready = 1'b1;
        #1;
        total_cnt++; if (o_ready !== 1'b1) $display("FAIL bp_release_ready got %h want 1", o_ready); else pass_cnt++;
        tick();
        i_valid = 1'b0;
        total_cnt++;
        if (o_valid !== 1'b1 || o_result !== 32'd7 || o_rd !== 5'd4)
            $display("FAIL bp_next got v=%h r=%h rd=%h want v=1 r=7 rd=4", o_valid, o_result, o_rd);
        else pass_cnt++;
        tick();
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL bp_drain got %h want 0", o_valid); else pass_cnt++;
    endtask

    task automatic test_branch();
        i_ready = 1'b1;
        set_instr(AluAdd, 1'b0, 1'b0, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd0, 3'd3, 1'b0);
        tick();
        i_valid = 1'b0;
        total_cnt++; if (o_flush !== 1'b1) $display("FAIL blt_flush got %h want 1", o_flush); else pass_cnt++;
        total_cnt++; if (o_flush_pc !== 32'h120) $display("FAIL blt_pc got %h want 00000120", o_flush_pc); else pass_cnt++;
        total_cnt++; if (o_ready !== 1'b0) $display("FAIL blt_block got %h want 0", o_ready); else pass_cnt++;
        total_cnt++; if (o_valid !== 1'b1 || o_misaligned !== 1'b0) $display("FAIL blt_valid got %h/%h want 1/0", o_valid, o_misaligned); else pass_cnt++;
        tick();
        total_cnt++; if (o_flush !== 1'b0) $display("FAIL blt_pulse got %h want 0", o_flush); else pass_cnt++;
        set_instr(AluAdd, 1'b0, 1'b0, 32'h100, 32'hFFFFFFFF, 32'd1, 32'h20, 5'd0, 3'd5, 1'b0);
        tick();
        i_valid = 1'b0;
        total_cnt++; if (o_flush !== 1'b0 || o_valid !== 1'b1) $display("FAIL bltu_flush got %h/%h want 0/1", o_flush, o_valid); else pass_cnt++;
        total_cnt++; if (o_flush_pc !== 32'h120) $display("FAIL bltu_pc_hold got %h want 00000120", o_flush_pc); else pass_cnt++;
        tick();
        set_instr(AluAdd, 1'b0, 1'b0, 32'h200, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFF0, 5'd0, 3'd4, 1'b0);
        tick();
        i_valid = 1'b0;
        total_cnt++;
        if (o_flush !== 1'b1 || o_flush_pc !== 32'h1F0)
            $display("FAIL bge_taken got %h/%h want 1/000001f0", o_flush, o_flush_pc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_jalr_misaligned();
        i_ready = 1'b0;
        set_instr(AluAdd, 1'b0, 1'b0, 32'h40, 32'h203, 32'h0, 32'h0, 5'd1, 3'd7, 1'b1);
        tick();
        i_valid = 1'b0;
        total_cnt++; if (o_flush_pc !== 32'h202) $display("FAIL jalr_pc got %h want 00000202", o_flush_pc); else pass_cnt++;
        total_cnt++; if (o_misaligned !== 1'b1) $display("FAIL jalr_mis got %h want 1", o_misaligned); else pass_cnt++;
        total_cnt++; if (o_flush !== 1'b0) $display("FAIL jalr_flush got %h want 0", o_flush); else pass_cnt++;
        total_cnt++; if (o_result !== 32'h44) $display("FAIL jalr_link got %h want 00000044", o_result); else pass_cnt++;
        tick();
        total_cnt++; if (o_misaligned !== 1'b1 || o_valid !== 1'b1) $display("FAIL jalr_hold got %h/%h want 1/1", o_misaligned, o_valid); else pass_cnt++;
        i_ready = 1'b1;
        tick();
        total_cnt++; if (o_misaligned !== 1'b0 || o_valid !== 1'b0) $display("FAIL jalr_drain got %h/%h want 0/0", o_misaligned, o_valid); else pass_cnt++;
    endtask

    task automatic test_jal_wrap();
        i_ready = 1'b1;
        set_instr(AluAdd, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0, 32'h0, 32'h8, 5'd1, 3'd7, 1'b0);
        tick();
        i_valid = 1'b0;
        total_cnt++; if (o_flush_pc !== 32'h4) $display("FAIL jal_wrap_pc got %h want 00000004", o_flush_pc); else pass_cnt++;
        total_cnt++; if (o_result !== 32'h0) $display("FAIL jal_wrap_link got %h want 00000000", o_result); else pass_cnt++;
        total_cnt++; if (o_flush !== 1'b1) $display("FAIL jal_wrap_flush got %h want 1", o_flush); else pass_cnt++;
        tick();
    endtask

    task automatic test_flush();
        i_ready = 1'b0;
        set_instr(AluAdd, 1'b0, 1'b0, 32'h0, 32'd1, 32'd1, 32'h0, 5'd5, 3'd0, 1'b0);
        tick();
        i_flush = 1'b1;
        #1;
        total_cnt++; if (o_ready !== 1'b0) $display("FAIL flush_ready got %h want 0", o_ready); else pass_cnt++;
        tick();
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL flush_held got %h want 0", o_valid); else pass_cnt++;
        i_flush = 1'b0;
        tick();
        total_cnt++; if (o_valid !== 1'b1) $display("FAIL flush_reload got %h want 1", o_valid); else pass_cnt++;
        i_valid = 1'b0;
        i_flush = 1'b1;
        i_ready = 1'b1;
        tick();
        total_cnt++; if (o_valid !== 1'b0) $display("FAIL flush_with_ready got %h want 0", o_valid); else pass_cnt++;
        i_flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        set_instr(AluAdd, 1'b0, 1'b0, 32'h80, 32'd3, 32'd3, 32'h10, 5'd7, 3'd1, 1'b0);
        tick();
        i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (o_valid !== 1'b0 || o_flush !== 1'b0 || o_misaligned !== 1'b0 || o_rd_write !== 1'b0 ||
            o_rd !== 5'd0 || o_result !== 32'h0 || o_flush_pc !== 32'h0)
            $display("FAIL mid_reset got v=%h f=%h m=%h w=%h rd=%h r=%h pc=%h want all 0",
                     o_valid, o_flush, o_misaligned, o_rd_write, o_rd, o_result, o_flush_pc);
        else pass_cnt++;
        #1;
        rst_n = 1'b1;
        tick();
        total_cnt++; if (o_valid !== 1'b0 || o_flush !== 1'b0) $display("FAIL post_reset got %h/%h want 0/0", o_valid, o_flush); else pass_cnt++;
        set_instr(AluAdd, 1'b0, 1'b0, 32'h0, 32'd2, 32'd2, 32'h0, 5'd9, 3'd0, 1'b0);
        tick();
        i_valid = 1'b0;
        total_cnt++; if (o_valid !== 1'b1 || o_result !== 32'd4) $display("FAIL post_reset_accept got %h/%h want 1/4", o_valid, o_result); else pass_cnt++;
    endtask

    initial begin
        pass_cnt        = 0;
        total_cnt       = 0;
        rst_n           = 1'b0;
        i_valid         = 1'b0;
        i_pc            = '0;
        i_rs1_value     = '0;
        i_rs2_value     = '0;
        i_imm_value     = '0;
        i_alu_operation = '0;
        i_rd            = '0;
        i_rd_write      = 1'b0;
        i_branch_op     = '0;
        i_jump_rs1      = 1'b0;
        i_flush         = 1'b0;
        i_ready         = 1'b0;

        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_branch();
        test_jalr_misaligned();
        test_jal_wrap();
        test_flush();
        test_reset_mid();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
